// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t  : fetch FSM states
//   WORD_BYTES     : PC step between sequential instructions
//   PC_READ_OFFSET : offset of the architectural R15 read value from pc
//   ADDR_MASK      : clears the byte-offset bits of a word address
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] WORD_BYTES     = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;
  localparam logic [31:0] ADDR_MASK      = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk    : clock
//   reset  : synchronous active-low reset, loads RESET_PC
//   load   : load target (word aligned), highest priority
//   incr   : advance by one word
//   target : load value; bits [1:0] are discarded
//   pc     : current program counter
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        incr,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target & ADDR_MASK;
    end else if (incr) begin
      pc_d = pc_q + WORD_BYTES;  // modulo 2^32 wrap is intended
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads over a req/ready
// handshake and presents one instruction at a time over valid/ready.
//   clk, reset                  : clock, synchronous active-low reset
//   imem_req/addr               : read request and word address to memory
//   imem_ready/rdata            : memory completion and returned word
//   instr, instr_valid          : instruction to decode and its valid flag
//   instr_ready                 : decode retires the presented instruction
//   pc, pc_plus8                : address of instr and the R15 read value
//   redirect, redirect_target   : taken branch / PC write, highest priority
// All outputs come from registered state only.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pending_q, pending_d;
  logic [31:0]  instr_q, instr_d;
  logic         pc_load;
  logic         pc_incr;
  logic [31:0]  pc_target;
  logic [31:0]  pc_q;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .incr  (pc_incr),
    .target(pc_target),
    .pc    (pc_q)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    instr_d   = instr_q;
    pc_load   = 1'b0;
    pc_incr   = 1'b0;
    pc_target = redirect_target;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        pc_load = redirect;
      end
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            // Returned word belongs to the old path; refetch from target.
            pc_load = 1'b1;
          end else begin
            instr_d = imem_rdata;
            state_d = VALID;
          end
        end else if (redirect) begin
          // Request stays in flight; remember where to go once it completes.
          pending_d = redirect_target & ADDR_MASK;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ready) begin
          pc_load   = 1'b1;
          pc_target = redirect ? redirect_target : pending_q;
          state_d   = FETCH;
        end else if (redirect) begin
          pending_d = redirect_target & ADDR_MASK;
        end
      end
      VALID: begin
        if (redirect) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end else if (instr_ready) begin
          pc_incr = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      instr_q   <= instr_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == VALID);
  assign pc          = pc_q;
  assign pc_plus8    = pc_q + PC_READ_OFFSET;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        redirect;
  logic [31:0] redirect_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hE5A0_0000;
  endfunction

  // Memory model: word depends on address, completion controlled by the bench.
  assign imem_rdata = word_of(imem_addr);

  fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc             (pc),
    .pc_plus8       (pc_plus8),
    .redirect       (redirect),
    .redirect_target(redirect_target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    imem_ready      = 1'b1;
    instr_ready     = 1'b1;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc8", pc_plus8, 32'h8);
    check("rst_instr", instr, 32'h0);

    // Zero-wait streaming: requests at 0,4,8,12 on alternating cycles
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq_req", {31'b0, imem_req}, 32'd1);
      check("seq_addr", imem_addr, 32'(4 * k));
      check("seq_nvalid", {31'b0, instr_valid}, 32'd0);
      step();
      check("seq_valid", {31'b0, instr_valid}, 32'd1);
      check("seq_instr", instr, word_of(32'(4 * k)));
      check("seq_pc8", pc_plus8, 32'(4 * k + 8));
      check("seq_noreq", {31'b0, imem_req}, 32'd0);
    end

    // Three wait cycles on address 4
    do_reset();
    step();
    step();
    imem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("wait_req", {31'b0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, 32'h4);
      check("wait_nvalid", {31'b0, instr_valid}, 32'd0);
      step();
    end
    imem_ready = 1'b1;
    check("wait_req4", {31'b0, imem_req}, 32'd1);
    check("wait_addr4", imem_addr, 32'h4);
    step();
    check("wait_valid", {31'b0, instr_valid}, 32'd1);
    check("wait_instr", instr, word_of(32'h4));

    // Hold in VALID at 0x10, then redirect to 0x103 flushes it
    do_reset();
    redirect        = 1'b1;
    redirect_target = 32'h10;
    step();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    check("hold_addr", imem_addr, 32'h10);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {31'b0, instr_valid}, 32'd1);
      check("hold_pc", pc, 32'h10);
      check("hold_instr", instr, word_of(32'h10));
      check("hold_noreq", {31'b0, imem_req}, 32'd0);
      check("hold_pc8", pc_plus8, 32'h18);
    end
    redirect        = 1'b1;
    redirect_target = 32'h103;
    instr_ready     = 1'b1;
    step();
    redirect = 1'b0;
    check("redir_req", {31'b0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_nvalid", {31'b0, instr_valid}, 32'd0);
    step();
    check("redir_valid", {31'b0, instr_valid}, 32'd1);
    check("redir_instr", instr, word_of(32'h100));
    check("redir_pc", pc, 32'h100);

    // Redirect during stalled FETCH of 0x20 drains the old request
    do_reset();
    redirect        = 1'b1;
    redirect_target = 32'h20;
    step();
    imem_ready      = 1'b0;
    redirect_target = 32'h200;
    step();
    redirect = 1'b0;
    check("drain_req", {31'b0, imem_req}, 32'd1);
    check("drain_addr", imem_addr, 32'h20);
    step();
    check("drain_addr2", imem_addr, 32'h20);
    check("drain_nvalid", {31'b0, instr_valid}, 32'd0);
    imem_ready = 1'b1;
    step();
    check("drain_new", imem_addr, 32'h200);
    check("drain_nvalid2", {31'b0, instr_valid}, 32'd0);
    step();
    check("drain_valid", {31'b0, instr_valid}, 32'd1);
    check("drain_instr", instr, word_of(32'h200));

    // Redirects stacked in DRAIN; last one coincides with ready
    do_reset();
    redirect        = 1'b1;
    redirect_target = 32'h20;
    step();
    imem_ready      = 1'b0;
    redirect_target = 32'h200;
    step();
    redirect_target = 32'h300;
    step();
    check("stack_addr", imem_addr, 32'h20);
    imem_ready      = 1'b1;
    redirect_target = 32'h400;
    step();
    redirect = 1'b0;
    check("stack_req", {31'b0, imem_req}, 32'd1);
    check("stack_new", imem_addr, 32'h400);
    check("stack_nvalid", {31'b0, instr_valid}, 32'd0);

    // Reset during a stalled request, then a late ready pulse
    do_reset();
    redirect        = 1'b1;
    redirect_target = 32'h40;
    step();
    redirect   = 1'b0;
    imem_ready = 1'b0;
    step();
    check("mid_addr", imem_addr, 32'h40);
    reset = 1'b0;
    step();
    check("mid_req", {31'b0, imem_req}, 32'd0);
    check("mid_nvalid", {31'b0, instr_valid}, 32'd0);
    check("mid_pc", pc, 32'h0);
    reset      = 1'b1;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("late_instr", instr, 32'h0);
    check("late_nvalid", {31'b0, instr_valid}, 32'd0);
    check("late_addr", imem_addr, 32'h0);

    // PC wrap at the top of the address space
    do_reset();
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_pc8", pc_plus8, 32'h4);
    step();
    check("wrap_instr", instr, word_of(32'hFFFF_FFFC));
    step();
    check("wrap_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
